// File: rtl/imem_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_prog_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - FSM state encoding (3 bits)
//   - bytes per instruction word and the index of the last byte in a word
//   - small helpers for state decoding and the running checksum
// No ports (package).
// -----------------------------------------------------------------------------
package imem_prog_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_LEN  = 3'd0;
    localparam state_t ST_DATA = 3'd1;
    localparam state_t ST_CHK  = 3'd2;
    localparam state_t ST_DONE = 3'd3;
    localparam state_t ST_ERR  = 3'd4;

    localparam int BYTES_PER_WORD = 32'sd4;
    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 32'sd1);

    // States in which the loader is consuming the byte stream.
    function automatic logic is_loading(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

    // One step of the 8-bit XOR checksum over the data bytes.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_prog_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_prog_loader_byte_packer
// Packs a byte stream little-endian into 32-bit words. The first three bytes
// of a word are held; the fourth is combined combinationally so the word is
// available in the same cycle the last byte is accepted.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   clr            synchronous clear of the byte count and held bytes
//   shift_en       a byte is being accepted this cycle
//   byte_in        the byte being accepted
//   word_valid     high when shift_en carries the 4th byte of a word
//   word           {b3,b2,b1,b0}; meaningful while word_valid is high
// -----------------------------------------------------------------------------
module imem_prog_loader_byte_packer
    import imem_prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_r;
    logic [23:0] hold_r;

    // New bytes enter at the top, so after b0,b1,b2 the hold register is {b2,b1,b0}.
    assign word       = {byte_in, hold_r};
    assign word_valid = shift_en && (cnt_r == LAST_BYTE_IDX);

    // Byte position counter (wraps 3 -> 0) and held lower bytes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r  <= 2'd0;
            hold_r <= 24'd0;
        end else if (clr) begin
            cnt_r  <= 2'd0;
            hold_r <= 24'd0;
        end else if (shift_en) begin
            cnt_r  <= cnt_r + 2'd1;
            hold_r <= {byte_in, hold_r[23:8]};
        end
    end

endmodule

// File: rtl/imem_prog_loader.sv
// -----------------------------------------------------------------------------
// imem_prog_loader
// Boot stage for the RV32I core. Receives a byte stream (4-byte little-endian
// word count N followed by N little-endian words), writes each word into the
// instruction memory and holds the core in reset until the load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- when defined, a trailing
// byte must equal the XOR of all data bytes or the load ends in ERR.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rx_valid/rx_data    incoming stream byte; rx_ready says it can be taken
//   reload              pulse that restarts loading from DONE or ERR
//   imem_we/addr/wdata  instruction-memory write port (one pulse per word)
//   core_rst            active-low reset to the core; released once loaded
//   busy/done/err       status: loading, finished, failed
// -----------------------------------------------------------------------------
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 32'sd10,
    parameter int MAX_WORDS = 32'sd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [31:0]         len_r;
    logic [ADDR_W-1:0]   word_idx_r;
    logic                rx_ready_r;
    logic                imem_we_r;
    logic [31:0]         imem_addr_r;
    logic [31:0]         imem_wdata_r;
    logic                core_rst_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic                accept_s;
    logic                shift_en_s;
    logic                restart_s;
    logic                word_valid_s;
    logic [31:0]         word_s;
    logic                data_word_s;
    logic                last_word_s;

    assign accept_s    = rx_valid && rx_ready_r;
    assign shift_en_s  = accept_s && ((state_r == ST_LEN) || (state_r == ST_DATA));
    assign restart_s   = reload && ((state_r == ST_DONE) || (state_r == ST_ERR));
    assign data_word_s = word_valid_s && (state_r == ST_DATA);
    assign last_word_s = ((32'(word_idx_r) + 32'd1) == len_r);

    imem_prog_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart_s),
        .shift_en   (shift_en_s),
        .byte_in    (rx_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    // The payload (including an empty one) is followed by the checksum byte.
    localparam state_t ST_AFTER_PAYLOAD = ST_CHK;

    logic [7:0] chk_r;

    // Running XOR over data bytes only; length bytes do not contribute.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chk_r <= 8'd0;
        end else if (restart_s) begin
            chk_r <= 8'd0;
        end else if (accept_s && (state_r == ST_DATA)) begin
            chk_r <= xor_fold(chk_r, rx_data);
        end
    end
`else
    localparam state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LEN: begin
                if (word_valid_s) begin
                    if (word_s == 32'd0) begin
                        state_nxt_s = ST_AFTER_PAYLOAD;
                    end else if (word_s > 32'(MAX_WORDS)) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DATA: begin
                if (data_word_s && last_word_s) begin
                    state_nxt_s = ST_AFTER_PAYLOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept_s) begin
                    state_nxt_s = (rx_data == chk_r) ? ST_DONE : ST_ERR;
                end else begin
                    state_nxt_s = state_r;
                end
`else
                // Unreachable without the checksum feature.
                state_nxt_s = ST_ERR;
`endif
            end
            ST_DONE, ST_ERR: begin
                if (reload) begin
                    state_nxt_s = ST_LEN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_ERR;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_LEN;
            len_r        <= 32'd0;
            word_idx_r   <= '0;
            rx_ready_r   <= 1'b1;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 32'd0;
            imem_wdata_r <= 32'd0;
            core_rst_r   <= 1'b0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rx_ready_r <= is_loading(state_nxt_s);
            busy_r     <= is_loading(state_nxt_s);
            done_r     <= (state_nxt_s == ST_DONE);
            err_r      <= (state_nxt_s == ST_ERR);
            // Release one cycle after entering DONE, i.e. after the final write
            // pulse; drop immediately when a reload leaves DONE.
            core_rst_r <= (state_r == ST_DONE) && (state_nxt_s == ST_DONE);
            imem_we_r  <= data_word_s;
            if (data_word_s) begin
                imem_addr_r  <= 32'({word_idx_r, 2'b00});
                imem_wdata_r <= word_s;
                word_idx_r   <= word_idx_r + ADDR_W'(1'b1);
            end
            if (word_valid_s && (state_r == ST_LEN)) begin
                len_r <= word_s;
            end
            if (restart_s) begin
                len_r      <= 32'd0;
                word_idx_r <= '0;
            end
        end
    end

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign core_rst   = core_rst_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_imem_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_prog_loader
// Directed and randomized loads of imem_prog_loader. Expected writes and final
// status are derived from the byte stream itself (length decode, little-endian
// word assembly, XOR checksum when IMEM_LOADER_CHECKSUM_EN is defined).
// -----------------------------------------------------------------------------
module tb_imem_prog_loader;

    localparam int MAX_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] got_addr_q[$];
    logic [31:0] got_data_q[$];

    imem_prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Log every write pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr_q.push_back(imem_addr);
            got_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"},       imem_we,    32'd0);
        check({tag, "_addr"},     imem_addr,  32'd0);
        check({tag, "_wdata"},    imem_wdata, 32'd0);
        check({tag, "_core_rst"}, core_rst,   32'd0);
        check({tag, "_busy"},     busy,       32'd1);
        check({tag, "_done"},     done,       32'd0);
        check({tag, "_err"},      err,        32'd0);
    endtask

    // Present one byte and hold it until accepted, then idle for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50; i++) begin
            ok = (rx_ready === 1'b1);
            tick();
            if (ok) break;
        end
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic pulse_reload(input string tag);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check({tag, "_busy"},     busy,     32'd1);
        check({tag, "_done"},     done,     32'd0);
        check({tag, "_err"},      err,      32'd0);
        check({tag, "_core_rst"}, core_rst, 32'd0);
        check({tag, "_rx_ready"}, rx_ready, 32'd1);
    endtask

    // Append the checksum byte when the feature is built.
    task automatic seal();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 4; i < stim_q.size(); i++) x ^= stim_q[i];
        stim_q.push_back(x);
`endif
    endtask

    task automatic build(input logic [31:0] n);
        stim_q.delete();
        for (int b = 0; b < 4; b++) stim_q.push_back(n[8*b +: 8]);
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < 4 * int'(n); i++) stim_q.push_back(8'($urandom));
            seal();
        end
    endtask

    task automatic set_directed();
        stim_q = {8'h02, 8'h00, 8'h00, 8'h00,
                  8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00};
        seal();
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return {stim_q[4*k+7], stim_q[4*k+6], stim_q[4*k+5], stim_q[4*k+4]};
    endfunction

    // Send stim_q and check writes, release timing and final status against
    // what the stream itself dictates.
    task automatic run_load(input string tag, input int gap, input int reload_at);
        logic [31:0] n;
        bit          exp_ok;
        int          exp_writes;
        int          last;
        n = {stim_q[3], stim_q[2], stim_q[1], stim_q[0]};
        exp_writes = 0;
        exp_ok     = 1'b0;
        if (n <= MAX_WORDS) begin
            exp_writes = int'(n);
            exp_ok     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 4; i < 4 + 4 * exp_writes; i++) x ^= stim_q[i];
                exp_ok = (stim_q[4 + 4 * exp_writes] == x);
            end
`endif
        end
        got_addr_q.delete();
        got_data_q.delete();
        last = stim_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (i == reload_at) begin
                reload = 1'b1;
                tick();
                reload = 1'b0;
                check({tag, "_reload_ignored"}, busy, 32'd1);
            end
            send_byte(stim_q[i], (i == last) ? 0 : gap);
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (exp_writes > 0) begin
            check({tag, "_we_latency"},  imem_we,    32'd1);
            check({tag, "_last_addr"},   imem_addr,  32'((exp_writes - 1) * 4));
            check({tag, "_last_wdata"},  imem_wdata, exp_word(exp_writes - 1));
        end
`endif
        check({tag, "_core_rst_early"}, core_rst, 32'd0);
        tick();
        check({tag, "_core_rst"}, core_rst, 32'(exp_ok));
        check({tag, "_we_idle"},  imem_we,  32'd0);
        tick();
        tick();
        check({tag, "_done"},     done,     32'(exp_ok));
        check({tag, "_err"},      err,      32'(!exp_ok));
        check({tag, "_busy"},     busy,     32'd0);
        check({tag, "_rx_ready"}, rx_ready, 32'd0);
        check({tag, "_n_writes"}, 32'(got_addr_q.size()), 32'(exp_writes));
        for (int k = 0; k < exp_writes && k < got_addr_q.size(); k++) begin
            check({tag, "_addr"},  got_addr_q[k], 32'(k * 4));
            check({tag, "_wdata"}, got_data_q[k], exp_word(k));
        end
    endtask

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) tick();
        check_reset("reset");

        // rst has priority over a simultaneous reload.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check_reset("reset_vs_reload");

        rst = 1'b1;
        tick();
        check("ready_after_reset", rx_ready, 32'd1);

        // Directed two-word program at full rate, then with 5-cycle gaps.
        set_directed();
        run_load("t1", 0, -1);
        check("t1_word0", got_data_q[0], 32'h0000_0013);
        check("t1_word1", got_data_q[1], 32'h0010_0093);
        pulse_reload("t1_reload");

        run_load("t2", 5, -1);
        check("t2_word0", got_data_q[0], 32'h0000_0013);
        check("t2_word1", got_data_q[1], 32'h0010_0093);
        pulse_reload("t2_reload");

        // Empty program.
        build(32'd0);
        run_load("len0", 0, -1);
        pulse_reload("len0_reload");

        // Over-length program, then recovery with a 1-word load.
        build(32'(MAX_WORDS + 1));
        run_load("len_over", 0, -1);
        check("len_over_err", err, 32'd1);
        pulse_reload("len_over_reload");
        build(32'd1);
        run_load("after_err", 0, -1);
        pulse_reload("after_err_reload");

        // Reset after 5 of 8 data bytes, then a fresh load from address 0.
        set_directed();
        for (int i = 0; i < 9; i++) send_byte(stim_q[i], 0);
        rst = 1'b0;
        tick();
        check_reset("midrst");
        rst = 1'b1;
        tick();
        run_load("fresh", 0, -1);
        check("fresh_first_addr", got_addr_q[0], 32'h0000_0000);
        pulse_reload("fresh_reload");

        // reload is ignored while in LEN and DATA.
        build(32'd3);
        run_load("rl_len", 0, 2);
        pulse_reload("rl_len_reload");
        build(32'd2);
        run_load("rl_data", 1, 7);
        pulse_reload("rl_data_reload");

        // Randomized lengths, gaps and contents.
        for (int t = 0; t < 6; t++) begin
            build(32'($urandom_range(1, 12)));
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 1) == 1) stim_q[stim_q.size() - 1] ^= 8'h01;
`endif
            run_load("rand", int'($urandom_range(0, 3)), -1);
            pulse_reload("rand_reload");
        end

        // Random huge length field.
        build(32'h8000_0000 | 32'($urandom));
        run_load("len_huge", 0, -1);
        pulse_reload("len_huge_reload");

        // Largest accepted program.
        build(32'(MAX_WORDS));
        run_load("max", 0, -1);
        pulse_reload("max_reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q = {8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        run_load("chk_good", 0, -1);
        check("chk_good_done", done, 32'd1);
        pulse_reload("chk_good_reload");
        stim_q[8] = 8'h01;
        run_load("chk_bad", 0, -1);
        check("chk_bad_err", err, 32'd1);
        check("chk_bad_core_rst", core_rst, 32'd0);
        pulse_reload("chk_bad_reload");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Upstream boot stage for the single-cycle RV32I core.
- Accepts a byte stream over a valid/ready handshake (from a UART receiver or testbench) and packs it little-endian into 32-bit words.
- Writes each word into the instruction memory write port and holds the core in reset until the program is fully loaded.
- Its core_rst output drives the processor's active-low rst input.

Parameters:
- ADDR_W, 10: instruction-memory word-address width; capacity is 2**ADDR_W words.
- MAX_WORDS, 1024: largest accepted program length in words; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (sampled on rising clk).
- rx_valid  in  1  stream byte valid.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle pulse that restarts loading from DONE or ERR.
- imem_we  out  1  instruction-memory write enable (one-cycle pulse per word).
- imem_addr  out  32  byte address of the written word; bits [1:0] always 0.
- imem_wdata  out  32  packed word {b3,b2,b1,b0}.
- core_rst  out  1  active-low reset to the core; 0 while loading.
- busy  out  1  high in LEN, DATA, CHK.
- done  out  1  high in DONE.
- err  out  1  high in ERR.

Behaviour:
- Reset (rst=0 at posedge):
  - State LEN; byte counter, word index, length and checksum cleared.
  - Outputs: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, busy=1, done=0, err=0.
  - rx_ready=1 on the first cycle after reset is released.
- Handshake:
  - A byte transfers on a posedge where rx_valid && rx_ready.
  - rx_ready is 1 in LEN, DATA and CHK, and 0 in DONE and ERR.
  - rx_ready never depends combinationally on rx_valid.
- LEN state:
  - Collects 4 bytes, little-endian, as the word count N.
  - On the 4th byte:
    - N=0 → DONE (or CHK with checksum 0 when the macro is enabled).
    - N>MAX_WORDS → ERR.
    - Otherwise → DATA.
- DATA state:
  - Shifts bytes into a 32-bit assembly register.
  - On the 4th byte of word k, the next cycle has imem_we=1, imem_addr=k*4, imem_wdata=assembled word.
  - imem_we is 0 in every other cycle; imem_addr and imem_wdata hold their last values.
  - Write latency is 1 cycle after the accepting edge. Back-to-back bytes at full rate are supported.
  - The byte counter wraps 3→0. The word index increments after each write.
  - After word N-1 is accepted → DONE (or CHK).
- Gaps: rx_valid may drop at any point; state and partial words are held indefinitely. There is no timeout.
- DONE state:
  - core_rst=1 from the cycle after the last imem_we pulse, so the core starts fetching at PC 0 with the memory fully written.
- ERR state:
  - core_rst stays 0 and err=1; no further writes occur.
- reload:
  - A pulse in DONE or ERR → LEN, counters cleared, core_rst=0 the next cycle.
  - Ignored in LEN, DATA and CHK.
- rst mid-load: the load is aborted and everything returns to the reset state. Memory contents already written are left as-is.
- Simultaneous rst=0 and reload: rst wins.
- Arithmetic: imem_addr = {word_idx, 2'b00}, zero-extended to 32 bits. word_idx is ADDR_W bits wide and never wraps because N ≤ MAX_WORDS.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR is kept over all data bytes (length bytes excluded).
  - After the last data byte the FSM enters CHK and accepts exactly one byte.
  - Byte equals the XOR → DONE. Byte differs → ERR (core_rst stays 0).
- Undefined: the CHK state and checksum register are not built, and the last data byte goes straight to DONE.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_LEN=0, ST_DATA=1, ST_CHK=2, ST_DONE=3, ST_ERR=4 (3 bits).
  - BYTES_PER_WORD=4.
- One sub-module is natural: byte_packer. It shifts in bytes, counts 0..3, and asserts word_valid with the packed word.

Test Plan:
- Reset, then stream length 2 plus bytes 13 00 00 00 93 00 10 00 at full rate → two writes: (addr 0x0, 0x00000013) and (addr 0x4, 0x00100093); core_rst rises the cycle after the second imem_we; done=1.
- Same stream with rx_valid deasserted for 5 cycles between every byte → identical writes and values; no spurious imem_we.
- Length 0 → no imem_we; DONE (macro off), with core_rst=1 two cycles after the 4th length byte.
- Length MAX_WORDS+1 (0x401 at default) → ERR; err=1, core_rst=0, rx_ready=0, no writes; then a reload pulse → busy=1, and a valid 1-word load completes.
- rst=0 asserted after 5 of 8 data bytes → reset values next cycle; a fresh full load then writes from address 0.
- With IMEM_LOADER_CHECKSUM_EN, 1 word AA BB CC DD:
  - Checksum byte 0x00 → DONE.
  - Checksum byte 0x01 → ERR with core_rst=0.
